sc_traffic_row_register: RTL and testbench

//  One Frogger traffic/river row: 8-bit occupancy register that rotates left/right at a programmable rate.

---
 rtl/sc_frogger_pkg.sv | 22 ++
 rtl/sc_traffic_row_register_if.sv | 38 +++
 rtl/sc_shift_prescaler.sv | 44 ++++
 rtl/sc_traffic_row_register.sv | 109 ++++++++++
 tb/tb_sc_traffic_row_register.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sc_frogger_pkg.sv
// Shared Frogger definitions: shift-selection codes, row activity encodings and
// the default row width used by every traffic/river row.
package sc_frogger_pkg;

    localparam int DATAWIDTH_BUS_DEFAULT = 8;

    localparam logic [1:0] SHIFT_LEFT  = 2'b00;
    localparam logic [1:0] SHIFT_RIGHT = 2'b01;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } activity_e;

    // Codes 0x move the row; 1x (either 10 or 11) hold it.
    function automatic logic sel_is_run(input logic [1:0] sel);
        return ~sel[1];
    endfunction

endpackage

// File: rtl/sc_traffic_row_register_if.sv
// Control/data bundle between the game state machine and one traffic row.
interface sc_traffic_row_register_if #(
    parameter int DW = 8
);
    logic          SC_TRAFFICROW_clear_InLow;
    logic          SC_TRAFFICROW_load_InLow;
    logic [1:0]    SC_TRAFFICROW_shiftselection_In;
    logic [1:0]    SC_TRAFFICROW_level_In;
    logic [DW-1:0] SC_TRAFFICROW_data_In;
    logic [DW-1:0] SC_TRAFFICROW_frogmask_In;
    logic [DW-1:0] SC_TRAFFICROW_data_Out;
    logic          SC_TRAFFICROW_tick_Out;
    logic          SC_TRAFFICROW_collision_OutLow;

    modport master (
        output SC_TRAFFICROW_clear_InLow,
        output SC_TRAFFICROW_load_InLow,
        output SC_TRAFFICROW_shiftselection_In,
        output SC_TRAFFICROW_level_In,
        output SC_TRAFFICROW_data_In,
        output SC_TRAFFICROW_frogmask_In,
        input  SC_TRAFFICROW_data_Out,
        input  SC_TRAFFICROW_tick_Out,
        input  SC_TRAFFICROW_collision_OutLow
    );

    modport slave (
        input  SC_TRAFFICROW_clear_InLow,
        input  SC_TRAFFICROW_load_InLow,
        input  SC_TRAFFICROW_shiftselection_In,
        input  SC_TRAFFICROW_level_In,
        input  SC_TRAFFICROW_data_In,
        input  SC_TRAFFICROW_frogmask_In,
        output SC_TRAFFICROW_data_Out,
        output SC_TRAFFICROW_tick_Out,
        output SC_TRAFFICROW_collision_OutLow
    );
endinterface

// File: rtl/sc_shift_prescaler.sv
// Programmable-rate prescaler: counts 0..P-1 with P = SHIFT_PERIOD >> level and
// strobes tick_o combinationally in the cycle whose edge wraps the count.
module sc_shift_prescaler #(
    parameter int PRESCALER_WIDTH = 25,
    parameter int SHIFT_PERIOD    = 25_000_000
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [1:0] level_i,
    output logic       tick_o
);

    logic [PRESCALER_WIDTH-1:0] count_q;
    logic [PRESCALER_WIDTH-1:0] count_d;
    logic [PRESCALER_WIDTH-1:0] period;
    logic [PRESCALER_WIDTH-1:0] last_count;

    assign period     = PRESCALER_WIDTH'(SHIFT_PERIOD) >> level_i;
    assign last_count = period - PRESCALER_WIDTH'(1);

    // Using >= rather than == means a level increase mid-count wraps at once
    // instead of running the counter past the new, shorter period.
    assign tick_o = enable_i && !clear_i && (count_q >= last_count);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = tick_o ? '0 : count_q + PRESCALER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sc_traffic_row_register.sv
// One Frogger traffic/river row: rotating occupancy register with a registered
// collision flag against the frog mask and a RUN/PAUSED/IDLE activity state.
module sc_traffic_row_register
    import sc_frogger_pkg::*;
#(
    parameter int DATAWIDTH_BUS   = DATAWIDTH_BUS_DEFAULT,
    parameter int PRESCALER_WIDTH = 25,
    parameter int SHIFT_PERIOD    = 25_000_000
) (
    input  logic                        SC_TRAFFICROW_CLOCK_50,
    input  logic                        SC_TRAFFICROW_RESET_InHigh,
    sc_traffic_row_register_if.slave    bus
);

    localparam int DW = DATAWIDTH_BUS;

    logic          clk;
    logic          srst;
    logic          clear_req;
    logic          load_req;
    logic          run_sel;
    logic          wrap;
    logic [1:0]    sel;

    logic [DW-1:0] row_q;
    logic [DW-1:0] row_d;
    logic          tick_q;
    logic          tick_d;
    logic          coll_n_q;
    logic          coll_n_d;
    activity_e     state_q;

    logic [DW-1:0] rot_left;
    logic [DW-1:0] rot_right;

    assign clk       = SC_TRAFFICROW_CLOCK_50;
    assign srst      = SC_TRAFFICROW_RESET_InHigh;
    assign clear_req = ~bus.SC_TRAFFICROW_clear_InLow;
    assign load_req  = ~bus.SC_TRAFFICROW_load_InLow;
    assign sel       = bus.SC_TRAFFICROW_shiftselection_In;
    assign run_sel   = sel_is_run(sel);

    sc_shift_prescaler #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH),
        .SHIFT_PERIOD    (SHIFT_PERIOD)
    ) u_prescaler (
        .clk      (clk),
        .srst     (srst),
        .enable_i (run_sel),
        .clear_i  (clear_req | load_req),
        .level_i  (bus.SC_TRAFFICROW_level_In),
        .tick_o   (wrap)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_rot
            assign rot_left[gi]  = row_q[(gi + DW - 1) % DW];
            assign rot_right[gi] = row_q[(gi + 1) % DW];
        end
    endgenerate

    always_comb begin
        row_d  = row_q;
        tick_d = 1'b0;
        if (clear_req) begin
            row_d = '0;
        end else if (load_req) begin
            row_d = bus.SC_TRAFFICROW_data_In;
        end else if (wrap) begin
            tick_d = 1'b1;
            case (sel)
                SHIFT_LEFT:  row_d = rot_left;
                SHIFT_RIGHT: row_d = rot_right;
                default:     row_d = row_q;
            endcase
        end
        // Compare against the next row value so the flag lines up with data_Out.
        coll_n_d = clear_req ? 1'b1 : ~|(row_d & bus.SC_TRAFFICROW_frogmask_In);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            row_q    <= '0;
            tick_q   <= 1'b0;
            coll_n_q <= 1'b1;
            state_q  <= ST_IDLE;
        end else begin
            row_q    <= row_d;
            tick_q   <= tick_d;
            coll_n_q <= coll_n_d;
            if (clear_req) begin
                state_q <= ST_IDLE;
            end else if (!load_req) begin
                case (state_q)
                    ST_IDLE:   if (run_sel)  state_q <= ST_RUN;
                    ST_RUN:    if (!run_sel) state_q <= ST_PAUSED;
                    ST_PAUSED: if (run_sel)  state_q <= ST_RUN;
                    default:                 state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.SC_TRAFFICROW_data_Out         = row_q;
    assign bus.SC_TRAFFICROW_tick_Out         = tick_q;
    assign bus.SC_TRAFFICROW_collision_OutLow = coll_n_q;

endmodule

// File: tb/tb_sc_traffic_row_register.sv
// Scoreboard bench for one traffic row: stimulus pushes expected per-cycle
// outputs from a rule-level model, a monitor pops and compares after each edge.
module tb_sc_traffic_row_register;
    import sc_frogger_pkg::*;

    localparam int PERIOD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_traffic_row_register_if #(.DW(8)) bus ();

    sc_traffic_row_register #(
        .DATAWIDTH_BUS   (8),
        .PRESCALER_WIDTH (25),
        .SHIFT_PERIOD    (PERIOD)
    ) dut (
        .SC_TRAFFICROW_CLOCK_50     (clk),
        .SC_TRAFFICROW_RESET_InHigh (rst),
        .bus                        (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       tick;
        logic       coll_n;
        logic [1:0] st;
        int         kind;   // 0 plain, 1 reset, 2 clear, 3 load, 4 shift
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state, in terms of the row rules only.
    int unsigned m_row = 0;
    int unsigned m_cnt = 0;
    logic [1:0]  m_st  = ST_IDLE;
    logic        m_tick = 1'b0;
    logic        m_coll_n = 1'b1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit r, input bit cl_n, input bit ld_n, input logic [1:0] sel,
                        input logic [1:0] lvl, input logic [7:0] din, input logic [7:0] fm);
        exp_t e;
        int unsigned p;
        @(negedge clk);
        rst = r;
        bus.SC_TRAFFICROW_clear_InLow       = cl_n;
        bus.SC_TRAFFICROW_load_InLow        = ld_n;
        bus.SC_TRAFFICROW_shiftselection_In = sel;
        bus.SC_TRAFFICROW_level_In          = lvl;
        bus.SC_TRAFFICROW_data_In           = din;
        bus.SC_TRAFFICROW_frogmask_In       = fm;
        e.kind = 0;
        m_tick = 1'b0;
        if (r) begin
            m_row = 0; m_cnt = 0; m_coll_n = 1'b1; m_st = ST_IDLE; e.kind = 1;
        end else if (!cl_n) begin
            m_row = 0; m_cnt = 0; m_coll_n = 1'b1; m_st = ST_IDLE; e.kind = 2;
        end else begin
            if (!ld_n) begin
                m_row = din; m_cnt = 0; e.kind = 3;
            end else begin
                p = PERIOD / (1 << lvl);
                if (sel == 2'b00 || sel == 2'b01) begin
                    if (m_cnt + 1 >= p) begin
                        m_cnt  = 0;
                        m_tick = 1'b1;
                        e.kind = 4;
                        if (sel == 2'b00) m_row = ((m_row * 2) % 256) + (m_row / 128);
                        else              m_row = (m_row / 2) + ((m_row % 2) * 128);
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                    m_st = ST_RUN;
                end else if (m_st == ST_RUN) begin
                    m_st = ST_PAUSED;
                end
            end
            m_coll_n = ((m_row & fm) == 0);
        end
        e.data   = m_row[7:0];
        e.tick   = m_tick;
        e.coll_n = m_coll_n;
        e.st     = m_st;
        q.push_back(e);
    endtask

    // Directed spot check of DUT outputs just after the edge of the last step.
    task automatic expect_dut(input string name, input logic [7:0] d, input logic t, input logic c);
        @(posedge clk);
        #2;
        chk({name, ".data"}, int'(bus.SC_TRAFFICROW_data_Out), int'(d));
        chk({name, ".tick"}, int'(bus.SC_TRAFFICROW_tick_Out), int'(t));
        chk({name, ".coll"}, int'(bus.SC_TRAFFICROW_collision_OutLow), int'(c));
    endtask

    task automatic run(input int n, input logic [1:0] sel, input logic [1:0] lvl, input logic [7:0] fm);
        for (int i = 0; i < n; i++) step(0, 1, 1, sel, lvl, 8'h00, fm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb.data", int'(bus.SC_TRAFFICROW_data_Out), int'(e.data));
                chk("sb.tick", int'(bus.SC_TRAFFICROW_tick_Out), int'(e.tick));
                chk("sb.coll", int'(bus.SC_TRAFFICROW_collision_OutLow), int'(e.coll_n));
                chk("sb.state", int'(dut.state_q), int'(e.st));
                if (e.kind != 0)
                    $display("[%0t] kind=%0d data=%08b tick=%0b coll_n=%0b state=%0d",
                             $time, e.kind, bus.SC_TRAFFICROW_data_Out, bus.SC_TRAFFICROW_tick_Out,
                             bus.SC_TRAFFICROW_collision_OutLow, dut.state_q);
            end
        end
    end

    initial begin : stimulus
        logic [1:0] sel;
        logic [1:0] lvl;
        logic [7:0] fm;
        int         r;
        bus.SC_TRAFFICROW_clear_InLow       = 1'b1;
        bus.SC_TRAFFICROW_load_InLow        = 1'b1;
        bus.SC_TRAFFICROW_shiftselection_In = SHIFT_HOLD;
        bus.SC_TRAFFICROW_level_In          = 2'b00;
        bus.SC_TRAFFICROW_data_In           = 8'h00;
        bus.SC_TRAFFICROW_frogmask_In       = 8'h00;

        // Reset for two cycles, then release while holding.
        step(1, 1, 1, SHIFT_HOLD, 0, 8'h00, 8'h00);
        step(1, 1, 1, SHIFT_HOLD, 0, 8'h00, 8'h00);
        step(0, 1, 1, SHIFT_HOLD, 0, 8'h00, 8'h00);
        expect_dut("reset", 8'h00, 1'b0, 1'b1);

        // Rotate left at level 0.
        step(0, 1, 0, 2'b10, 0, 8'b0000_0011, 8'h00);
        run(7, SHIFT_LEFT, 0, 8'h00);
        step(0, 1, 1, SHIFT_LEFT, 0, 8'h00, 8'h00);
        expect_dut("left1", 8'b0000_0110, 1'b1, 1'b1);
        step(0, 1, 1, SHIFT_LEFT, 0, 8'h00, 8'h00);
        expect_dut("left1_pulse", 8'b0000_0110, 1'b0, 1'b1);
        run(6, SHIFT_LEFT, 0, 8'h00);
        step(0, 1, 1, SHIFT_LEFT, 0, 8'h00, 8'h00);
        expect_dut("left2", 8'b0000_1100, 1'b1, 1'b1);

        // Rotate right with wrap, then a full revolution.
        step(0, 1, 0, 2'b10, 0, 8'b0000_0001, 8'h00);
        run(7, SHIFT_RIGHT, 0, 8'h00);
        step(0, 1, 1, SHIFT_RIGHT, 0, 8'h00, 8'h00);
        expect_dut("right_wrap", 8'b1000_0000, 1'b1, 1'b1);
        run(55, SHIFT_RIGHT, 0, 8'h00);
        step(0, 1, 1, SHIFT_RIGHT, 0, 8'h00, 8'h00);
        expect_dut("right_full", 8'b0000_0001, 1'b1, 1'b1);

        // Hold at count 5 for 20 cycles; resume continues from the frozen count.
        step(0, 1, 0, 2'b10, 0, 8'b0000_0001, 8'h00);
        run(5, SHIFT_RIGHT, 0, 8'h00);
        run(19, SHIFT_HOLD, 0, 8'h00);
        step(0, 1, 1, SHIFT_HOLD, 0, 8'h00, 8'h00);
        expect_dut("hold", 8'b0000_0001, 1'b0, 1'b1);
        run(2, SHIFT_RIGHT, 0, 8'h00);
        step(0, 1, 1, SHIFT_RIGHT, 0, 8'h00, 8'h00);
        expect_dut("resume", 8'b1000_0000, 1'b1, 1'b1);

        // Level jump at count 6 wraps immediately, then period 2.
        step(0, 1, 0, 2'b10, 0, 8'b0000_0001, 8'h00);
        run(6, SHIFT_LEFT, 0, 8'h00);
        step(0, 1, 1, SHIFT_LEFT, 2, 8'h00, 8'h00);
        expect_dut("lvl_jump", 8'b0000_0010, 1'b1, 1'b1);
        step(0, 1, 1, SHIFT_LEFT, 2, 8'h00, 8'h00);
        expect_dut("lvl_gap", 8'b0000_0010, 1'b0, 1'b1);
        step(0, 1, 1, SHIFT_LEFT, 2, 8'h00, 8'h00);
        expect_dut("lvl_p2", 8'b0000_0100, 1'b1, 1'b1);

        // Collision on load, then clear beats a simultaneous load.
        step(0, 1, 0, SHIFT_HOLD, 0, 8'b0001_0000, 8'b0001_0000);
        expect_dut("coll_load", 8'b0001_0000, 1'b0, 1'b0);
        step(0, 0, 0, SHIFT_HOLD, 0, 8'b1111_1111, 8'b0001_0000);
        expect_dut("clear_wins", 8'h00, 1'b0, 1'b1);

        // Randomized phase.
        sel = SHIFT_LEFT;
        lvl = 2'b00;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 9) == 0)  sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) lvl = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 8);
            fm = (r == 8) ? 8'h00 : 8'(1 << r);
            step(($urandom_range(0, 249) == 0), ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 19) != 0), sel, lvl, 8'($urandom_range(0, 255)), fm);
        end

        @(posedge clk);
        #3;
        chk("sb.drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
